// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB-to-memory bridge.
// State encoding, default widths, and a constant clog2.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/apb_mem_bridge_if.sv
// APB completer-side bus bundle for apb_mem_bridge.
// master: drives PADDR/PWRITE/PSEL/PENABLE/PWDATA(/PSTRB with
//   APB_PSTRB_EN); slave: drives PREADY/PSLVERR/PRDATA.
interface apb_mem_bridge_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [ADDR_W-1:0]   PADDR;
    logic                PWRITE;
    logic                PSEL;
    logic                PENABLE;
    logic [DATA_W-1:0]   PWDATA;
`ifdef APB_PSTRB_EN
    logic [DATA_W/8-1:0] PSTRB;
`endif
    logic                PREADY;
    logic                PSLVERR;
    logic [DATA_W-1:0]   PRDATA;

    modport master (
        output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
`ifdef APB_PSTRB_EN
        output PSTRB,
`endif
        input  PREADY, PSLVERR, PRDATA
    );

    modport slave (
        input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
`ifdef APB_PSTRB_EN
        input  PSTRB,
`endif
        output PREADY, PSLVERR, PRDATA
    );

endinterface

// File: rtl/apb_region_decoder.sv
// Combinational address-window decoder, lowest channel wins.
// Ports: addr_i, base_i/limit_i (slice per channel) -> hit_o, sel_o (one-hot).
module apb_region_decoder #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [NUM_CH*ADDR_W-1:0] base_i,
    input  logic [NUM_CH*ADDR_W-1:0] limit_i,
    output logic                     hit_o,
    output logic [NUM_CH-1:0]        sel_o
);

    always_comb begin
        hit_o = 1'b0;
        sel_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!hit_o &&
                addr_i >= base_i[i*ADDR_W +: ADDR_W] &&
                addr_i <= limit_i[i*ADDR_W +: ADDR_W]) begin
                hit_o    = 1'b1;
                sel_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_mem_bridge.sv
// APB completer forwarding each transfer to one of NUM_CH memory
// channels chosen by runtime base/limit windows, with grant timeout.
// Ports: PCLK, PRESETn (async low), apb (slave modport),
//   REGION_BASE/LIMIT, MEM_REQ/ADDR/WRITE/WDATA(/MEM_BE), MEM_GRANT/RDATA.
// Optional: define APB_PSTRB_EN for PSTRB/MEM_BE byte-enable support.
module apb_mem_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    apb_mem_bridge_if.slave          apb,
    input  logic [NUM_CH*ADDR_W-1:0] REGION_BASE,
    input  logic [NUM_CH*ADDR_W-1:0] REGION_LIMIT,
    output logic [NUM_CH-1:0]        MEM_REQ,
    output logic [ADDR_W-1:0]        MEM_ADDR,
    output logic                     MEM_WRITE,
    output logic [DATA_W-1:0]        MEM_WDATA,
`ifdef APB_PSTRB_EN
    output logic [DATA_W/8-1:0]      MEM_BE,
`endif
    input  logic [NUM_CH-1:0]        MEM_GRANT,
    input  logic [NUM_CH*DATA_W-1:0] MEM_RDATA
);

    localparam int CNT_RAW = clog2(TIMEOUT + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam int TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_CH-1:0]   req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
`ifdef APB_PSTRB_EN
    logic [DATA_W/8-1:0] be_q, be_d;
`endif

    logic                dec_hit;
    logic [NUM_CH-1:0]   dec_sel;
    logic                grant_hit;
    logic [DATA_W-1:0]   rdata_sel;

    apb_region_decoder #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W)
    ) u_dec (
        .addr_i  (apb.PADDR),
        .base_i  (REGION_BASE),
        .limit_i (REGION_LIMIT),
        .hit_o   (dec_hit),
        .sel_o   (dec_sel)
    );

    // req_q is one-hot on the selected channel throughout REQ,
    // so it doubles as the grant and read-data select.
    assign grant_hit = |(MEM_GRANT & req_q);

    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_q[i]) begin
                rdata_sel = rdata_sel | MEM_RDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        req_d     = req_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
`ifdef APB_PSTRB_EN
        be_d      = be_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Only a setup phase starts a transfer; a lone
                // PENABLE is ignored.
                if (apb.PSEL && !apb.PENABLE) begin
                    addr_d  = apb.PADDR;
                    write_d = apb.PWRITE;
                    wdata_d = apb.PWDATA;
`ifdef APB_PSTRB_EN
                    be_d = apb.PWRITE ? apb.PSTRB : '1;
`endif
                    if (!dec_hit) begin
                        state_d   = RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end
`ifdef APB_PSTRB_EN
                    else if (apb.PWRITE && apb.PSTRB == '0) begin
                        // Nothing to write: complete OKAY locally.
                        state_d  = RESP;
                        pready_d = 1'b1;
                    end
`endif
                    else begin
                        req_d   = dec_sel;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (!apb.PSEL) begin
                    req_d   = '0;
                    state_d = IDLE;
                end else if (grant_hit) begin
                    req_d    = '0;
                    state_d  = RESP;
                    pready_d = 1'b1;
                    if (!write_q) prdata_d = rdata_sel;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    req_d     = '0;
                    state_d   = RESP;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = '0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
`ifdef APB_PSTRB_EN
            be_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
`ifdef APB_PSTRB_EN
            be_q      <= be_d;
`endif
        end
    end

    assign MEM_REQ     = req_q;
    assign MEM_ADDR    = addr_q;
    assign MEM_WRITE   = write_q;
    assign MEM_WDATA   = wdata_q;
`ifdef APB_PSTRB_EN
    assign MEM_BE      = be_q;
`endif
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign apb.PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Self-checking bench for apb_mem_bridge (NUM_CH=2, TIMEOUT=4).
// Directed scenarios plus randomized transfers against a window model.
module tb_apb_mem_bridge;
    import apb_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NCH = 2;
    localparam int TO  = 4;

    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    apb_mem_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [NCH*AW-1:0] REGION_BASE, REGION_LIMIT;
    logic [NCH-1:0]    MEM_REQ, MEM_GRANT;
    logic [AW-1:0]     MEM_ADDR;
    logic              MEM_WRITE;
    logic [DW-1:0]     MEM_WDATA;
    logic [NCH*DW-1:0] MEM_RDATA;
`ifdef APB_PSTRB_EN
    logic [DW/8-1:0]   MEM_BE;
`endif

    apb_mem_bridge #(
        .ADDR_W (AW), .DATA_W (DW), .NUM_CH (NCH), .TIMEOUT (TO)
    ) dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .apb          (bus),
        .REGION_BASE  (REGION_BASE),
        .REGION_LIMIT (REGION_LIMIT),
        .MEM_REQ      (MEM_REQ),
        .MEM_ADDR     (MEM_ADDR),
        .MEM_WRITE    (MEM_WRITE),
        .MEM_WDATA    (MEM_WDATA),
`ifdef APB_PSTRB_EN
        .MEM_BE       (MEM_BE),
`endif
        .MEM_GRANT    (MEM_GRANT),
        .MEM_RDATA    (MEM_RDATA)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] base_m [NCH];
    logic [AW-1:0] lim_m  [NCH];
    logic [DW-1:0] data_m [NCH];

    int            obs_waits;
    logic          obs_err;
    logic [DW-1:0] obs_rdata;
    logic [NCH-1:0] obs_req;
    int            obs_req_cycles;
    logic          obs_unstable;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_wdata;
    logic          obs_write;
    logic          obs_pre_ready;

    task automatic set_env(input logic [AW-1:0] b0, l0, b1, l1,
                           input logic [DW-1:0] d0, d1);
        base_m[0] = b0; lim_m[0] = l0; data_m[0] = d0;
        base_m[1] = b1; lim_m[1] = l1; data_m[1] = d1;
        for (int i = 0; i < NCH; i++) begin
            REGION_BASE[i*AW +: AW]  = base_m[i];
            REGION_LIMIT[i*AW +: AW] = lim_m[i];
            MEM_RDATA[i*DW +: DW]    = data_m[i];
        end
    endtask

    // Window/timeout rules from the bridge description; g is the REQ
    // cycle index in which the target grants (-1 = never).
    function automatic void model(input logic [AW-1:0] a, input logic w,
                                  input int g, output int ch,
                                  output int waits, output logic err,
                                  output logic [DW-1:0] rd);
        ch = -1;
        for (int i = NCH - 1; i >= 0; i--)
            if (a >= base_m[i] && a <= lim_m[i]) ch = i;
        if (ch < 0) begin
            waits = 0; err = 1'b1; rd = '0;
        end else if (g >= 0 && (TO == 0 || g < TO)) begin
            waits = g + 1; err = 1'b0; rd = w ? '0 : data_m[ch];
        end else begin
            waits = TO; err = 1'b1; rd = '0;
        end
    endfunction

    task automatic xfer(input logic [AW-1:0] a, input logic w,
                        input logic [DW-1:0] wd, input int g);
        int k;
        int rq;
        logic done;
        logic [31:0] noise;
        obs_req = '0; obs_req_cycles = 0; obs_unstable = 1'b0;
        obs_waits = -1; obs_err = 1'bx; obs_rdata = 'x;
        @(negedge PCLK);
        obs_pre_ready = bus.PREADY;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        bus.PADDR = a; bus.PWRITE = w; bus.PWDATA = wd;
        MEM_GRANT = '0;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        obs_addr = MEM_ADDR; obs_wdata = MEM_WDATA; obs_write = MEM_WRITE;
        k = 0; rq = 0; done = 1'b0;
        while (!done) begin
            if (bus.PREADY) begin
                done = 1'b1;
                obs_waits = k; obs_err = bus.PSLVERR; obs_rdata = bus.PRDATA;
            end else if (k >= 40) begin
                done = 1'b1;
                n_tests++; n_fail++;
                $display("FAIL xfer_bound addr=%h: no PREADY within %0d cycles", a, k);
            end else begin
                if (MEM_REQ != '0) begin
                    if (obs_req_cycles == 0) obs_req = MEM_REQ;
                    else if (MEM_REQ !== obs_req) obs_unstable = 1'b1;
                    obs_req_cycles++;
                end
                noise = $urandom;
                MEM_GRANT = noise[NCH-1:0] & ~MEM_REQ;
                if (MEM_REQ != '0 && rq == g) MEM_GRANT = MEM_GRANT | MEM_REQ;
                if (MEM_REQ != '0) rq++;
                @(negedge PCLK);
                k++;
            end
        end
        MEM_GRANT = '0;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        repeat (2) @(negedge PCLK);
        n_tests++;
        if ({bus.PREADY, bus.PSLVERR, MEM_REQ, MEM_WRITE} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 0",
                     {bus.PREADY, bus.PSLVERR, MEM_REQ, MEM_WRITE});
        end
        n_tests++;
        if ({bus.PRDATA, MEM_ADDR, MEM_WDATA} !== '0) begin
            n_fail++;
            $display("FAIL reset_data prdata=%h addr=%h wdata=%h want 0",
                     bus.PRDATA, MEM_ADDR, MEM_WDATA);
        end
        PRESETn = 1'b1;
    endtask

    task automatic test_write_hit();
        set_env(32'h000, 32'h0FF, 32'h100, 32'h1FF, 32'hA5A5_0001, 32'h5A5A_0002);
        xfer(32'h104, 1'b1, 32'hDEAD_BEEF, 0);
        n_tests++;
        if (obs_req !== 2'b10 || obs_req_cycles != 1) begin
            n_fail++;
            $display("FAIL wr_req got %b x%0d want 10 x1", obs_req, obs_req_cycles);
        end
        n_tests++;
        if (obs_addr !== 32'h104 || obs_wdata !== 32'hDEAD_BEEF || obs_write !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_latch got %h/%h/%b want 104/deadbeef/1",
                     obs_addr, obs_wdata, obs_write);
        end
        n_tests++;
        if (obs_waits != 1 || obs_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_resp waits=%0d err=%b want 1/0", obs_waits, obs_err);
        end
    endtask

    task automatic test_read_wait();
        set_env(32'h000, 32'h0FF, 32'h100, 32'h1FF, 32'h1234_5678, 32'hCAFE_F00D);
        xfer(32'h010, 1'b0, 32'h0, 2);
        n_tests++;
        if (obs_rdata !== 32'h1234_5678 || obs_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_data got %h err=%b want 12345678/0", obs_rdata, obs_err);
        end
        n_tests++;
        if (obs_waits != 3 || obs_req !== 2'b01 || obs_req_cycles != 3 || obs_unstable) begin
            n_fail++;
            $display("FAIL rd_wait waits=%0d req=%b x%0d unst=%b want 3 01 x3 0",
                     obs_waits, obs_req, obs_req_cycles, obs_unstable);
        end
    endtask

    task automatic test_miss();
        xfer(32'h300, 1'b0, 32'h0, 0);
        n_tests++;
        if (obs_req_cycles != 0 || obs_waits != 0 || obs_err !== 1'b1 || obs_rdata !== '0) begin
            n_fail++;
            $display("FAIL miss req_cyc=%0d waits=%0d err=%b rd=%h want 0/0/1/0",
                     obs_req_cycles, obs_waits, obs_err, obs_rdata);
        end
    endtask

    task automatic test_timeout();
        xfer(32'h020, 1'b0, 32'h0, -1);
        n_tests++;
        if (obs_req_cycles != 4 || obs_waits != 4 || obs_err !== 1'b1 || obs_rdata !== '0) begin
            n_fail++;
            $display("FAIL timeout req_cyc=%0d waits=%0d err=%b rd=%h want 4/4/1/0",
                     obs_req_cycles, obs_waits, obs_err, obs_rdata);
        end
        xfer(32'h020, 1'b0, 32'h0, 3);
        n_tests++;
        if (obs_waits != 4 || obs_err !== 1'b0 || obs_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL grant_at_limit waits=%0d err=%b rd=%h want 4/0/12345678",
                     obs_waits, obs_err, obs_rdata);
        end
    endtask

    task automatic test_overlap();
        set_env(32'h000, 32'h1FF, 32'h000, 32'h1FF, 32'h1111_1111, 32'h2222_2222);
        xfer(32'h050, 1'b0, 32'h0, 1);
        n_tests++;
        if (obs_req !== 2'b01 || obs_rdata !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL overlap req=%b rd=%h want 01/11111111", obs_req, obs_rdata);
        end
    endtask

    task automatic test_reset_abort();
        logic bad;
        set_env(32'h000, 32'h0FF, 32'h100, 32'h1FF, 32'h1234_5678, 32'hCAFE_F00D);
        MEM_GRANT = '0;
        @(negedge PCLK);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        bus.PADDR = 32'h104; bus.PWRITE = 1'b1; bus.PWDATA = 32'h0BAD_F00D;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        @(negedge PCLK);
        #1 PRESETn = 1'b0;
        #1;
        n_tests++;
        if ({MEM_REQ, MEM_WRITE, bus.PREADY, bus.PSLVERR} !== '0 ||
            {MEM_ADDR, MEM_WDATA, bus.PRDATA} !== '0) begin
            n_fail++;
            $display("FAIL async_reset req=%b addr=%h wdata=%h rdy=%b",
                     MEM_REQ, MEM_ADDR, MEM_WDATA, bus.PREADY);
        end
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        bus.PADDR = 32'h104; bus.PWRITE = 1'b0;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        n_tests++;
        if (MEM_REQ !== 2'b10) begin
            n_fail++;
            $display("FAIL abort_req got %b want 10", MEM_REQ);
        end
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge PCLK);
            if (MEM_REQ !== '0 || bus.PREADY !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL abort_clear req=%b rdy=%b want 00/0", MEM_REQ, bus.PREADY);
        end
        xfer(32'h104, 1'b1, 32'h7777_0000, 0);
        n_tests++;
        if (obs_waits != 1 || obs_err !== 1'b0 || obs_req !== 2'b10) begin
            n_fail++;
            $display("FAIL after_abort waits=%0d err=%b req=%b want 1/0/10",
                     obs_waits, obs_err, obs_req);
        end
    endtask

    task automatic test_penable_only();
        logic bad;
        bad = 1'b0;
        @(negedge PCLK);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PADDR = 32'h010;
        repeat (3) begin
            @(negedge PCLK);
            if (MEM_REQ !== '0 || bus.PREADY !== 1'b0) bad = 1'b1;
        end
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL penable_only req=%b rdy=%b want 00/0", MEM_REQ, bus.PREADY);
        end
    endtask

    task automatic test_back_to_back();
        xfer(32'h0F0, 1'b0, 32'h0, 0);
        xfer(32'h1F0, 1'b0, 32'h0, 1);
        n_tests++;
        if (obs_pre_ready !== 1'b0 || obs_waits != 2 || obs_rdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL b2b pre_rdy=%b waits=%0d rd=%h want 0/2/cafef00d",
                     obs_pre_ready, obs_waits, obs_rdata);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a, b0, b1;
        logic [DW-1:0] wd;
        logic w;
        int g, ch, ew;
        logic ee;
        logic [DW-1:0] er;
        logic [NCH-1:0] ereq;
        for (int it = 0; it < 60; it++) begin
            b0 = AW'($urandom_range(0, 32'h300));
            b1 = AW'($urandom_range(0, 32'h300));
            set_env(b0, b0 + AW'($urandom_range(0, 32'h100)),
                    b1, b1 + AW'($urandom_range(0, 32'h100)),
                    $urandom, $urandom);
            a  = AW'($urandom_range(0, 32'h3FF));
            w  = 1'($urandom_range(0, 1));
            wd = $urandom;
            g  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
            model(a, w, g, ch, ew, ee, er);
            ereq = (ch < 0) ? '0 : NCH'(1 << ch);
            xfer(a, w, wd, g);
            n_tests++;
            if (obs_waits != ew || obs_err !== ee || obs_rdata !== er) begin
                n_fail++;
                $display("FAIL rnd_resp it=%0d a=%h w=%b g=%0d got %0d/%b/%h want %0d/%b/%h",
                         it, a, w, g, obs_waits, obs_err, obs_rdata, ew, ee, er);
            end
            n_tests++;
            if (obs_req !== ereq || obs_req_cycles != ((ch < 0) ? 0 : ew) || obs_unstable) begin
                n_fail++;
                $display("FAIL rnd_req it=%0d got %b x%0d unst=%b want %b x%0d",
                         it, obs_req, obs_req_cycles, obs_unstable, ereq,
                         (ch < 0) ? 0 : ew);
            end
            n_tests++;
            if (obs_addr !== a || obs_write !== w || obs_wdata !== wd) begin
                n_fail++;
                $display("FAIL rnd_latch it=%0d got %h/%b/%h want %h/%b/%h",
                         it, obs_addr, obs_write, obs_wdata, a, w, wd);
            end
        end
    endtask

    initial begin
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PADDR = '0;
        bus.PWRITE = 1'b0; bus.PWDATA = '0;
`ifdef APB_PSTRB_EN
        bus.PSTRB = '1;
`endif
        MEM_GRANT = '0;
        set_env(32'h000, 32'h0FF, 32'h100, 32'h1FF, 32'h0, 32'h0);
        test_reset();
        test_write_hit();
        test_read_wait();
        test_miss();
        test_timeout();
        test_overlap();
        test_reset_abort();
        test_penable_only();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_mem_bridge.md
Name: apb_mem_bridge

Overview:
- Parametrised APB slave bridging one APB completer port onto NUM_CH independent memory channels with a req/grant handshake.
- Decodes PADDR against per-channel runtime base/limit windows and forwards the transfer to the first matching channel.
- Bounds every transfer with a grant-timeout error.
- Sits between the APB master and memory/peripheral targets.

Parameters:
ADDR_W, 32, address width of PADDR and MEM_ADDR
DATA_W, 32, data width (multiple of 8)
NUM_CH, 4, number of memory channels (1..8)
TIMEOUT, 16, grant wait limit in cycles; 0 disables the timeout

Ports:
PCLK  in  1  clock
PRESETn  in  1  reset (asynchronous, active-low)
PADDR  in  ADDR_W  APB address
PWRITE  in  1  1=write
PSEL  in  1  slave select
PENABLE  in  1  access phase
PWDATA  in  DATA_W  write data
PSTRB  in  DATA_W/8  byte strobes (present only with APB_PSTRB_EN)
PREADY  out  1  transfer complete
PSLVERR  out  1  transfer error
PRDATA  out  DATA_W  read data
REGION_BASE  in  NUM_CH*ADDR_W  channel i lower bound, slice i
REGION_LIMIT  in  NUM_CH*ADDR_W  channel i upper bound inclusive, slice i
MEM_REQ  out  NUM_CH  one-hot request
MEM_ADDR  out  ADDR_W  latched address, shared
MEM_WRITE  out  1  latched direction
MEM_WDATA  out  DATA_W  latched write data
MEM_BE  out  DATA_W/8  byte enables (present only with APB_PSTRB_EN)
MEM_GRANT  in  NUM_CH  per-channel grant/done
MEM_RDATA  in  NUM_CH*DATA_W  per-channel read data, slice i

Behaviour:
- Reset (async): state IDLE; all outputs and counter at 0.
- All outputs are registered.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - On PSEL=1 and PENABLE=0, latch PADDR/PWRITE/PWDATA into MEM_ADDR/MEM_WRITE/MEM_WDATA.
  - Decode: hit_i = BASE_i <= PADDR <= LIMIT_i. The lowest index wins on overlap.
  - On a hit, set MEM_REQ[hit] and go to REQ.
  - On a miss, go to RESP with PSLVERR=1.
- REQ:
  - MEM_REQ stays one-hot and stable until grant.
  - Counter increments each cycle.
  - If MEM_GRANT[sel]=1, clear MEM_REQ and go to RESP with PSLVERR=0. On reads, capture PRDATA = MEM_RDATA[sel]; on writes, PRDATA=0.
  - Else if TIMEOUT != 0 and counter = TIMEOUT-1, clear MEM_REQ and go to RESP with PSLVERR=1, PRDATA=0.
  - Grant and timeout in the same cycle: grant wins.
  - Grants on unselected channels are ignored.
  - PSEL=0 while in REQ (master abort): clear MEM_REQ, go to IDLE, no PREADY.
- RESP:
  - PREADY=1 for exactly one cycle, then return to IDLE.
  - PREADY, PSLVERR and PRDATA clear on the exit edge.
  - Counter clears.
- Latency:
  - Miss: 0 wait states (PREADY in the first access cycle).
  - Hit with grant in the first REQ cycle: 1 wait state.
  - General: wait states = cycles until grant, maximum TIMEOUT.
- Counter width: $clog2(TIMEOUT+1), minimum 1; it never wraps.
- Back-to-back transfers: a new setup phase is accepted in the IDLE cycle that immediately follows RESP.
- PENABLE=1 seen in IDLE without a prior setup is ignored.

Optional Feature:
- Macro APB_PSTRB_EN:
  - Defined: PSTRB/MEM_BE ports exist. MEM_BE latches PSTRB on writes and is driven all-ones on reads. A write with PSTRB=0 completes as an OKAY response without issuing MEM_REQ.
  - Undefined: ports absent; targets perform full-word writes.

Decomposition:
- Shared package apb_pkg:
  - state encodings IDLE=2'd0, REQ=2'd1, RESP=2'd2
  - default ADDR_W/DATA_W constants
  - clog2 function
- Sub-module apb_region_decoder (combinational, parametrised NUM_CH/ADDR_W): outputs hit (1 bit) and sel (one-hot NUM_CH) using priority-lowest-index.

Test Plan:
1. NUM_CH=2, BASE0=0x000/LIMIT0=0x0FF, BASE1=0x100/LIMIT1=0x1FF; write 0xDEADBEEF to 0x104, grant in the first REQ cycle. Required: MEM_REQ=2'b10 for 1 cycle, MEM_ADDR=0x104, MEM_WDATA=0xDEADBEEF, PREADY after 1 wait state, PSLVERR=0.
2. Read 0x010 with grant after 3 cycles and MEM_RDATA slice0=0x12345678. Required: PRDATA=0x12345678, PREADY at wait state 3, PSLVERR=0.
3. Read 0x300 (no region). Required: no MEM_REQ, PREADY and PSLVERR in the first access cycle, PRDATA=0.
4. TIMEOUT=4, read 0x020 with grant never asserted. Required: MEM_REQ high for 4 cycles then cleared, PREADY=1/PSLVERR=1/PRDATA=0; a grant arriving in the same cycle as the limit yields PSLVERR=0.
5. Overlapping windows 0x000-0x1FF on both channels, access 0x050. Required: only MEM_REQ[0].
6. PRESETn low during REQ, then a PSEL drop during REQ. Required: all outputs 0 immediately on reset; on abort, MEM_REQ cleared, FSM returns to IDLE, no PREADY; the next transfer completes normally.
